// File: rtl/fifo_tx_ctrl_if.sv
// Handshake bundle of fifo_tx_ctrl: FIFO pop side, UART line and host status.
// master = the controller; slave = the FIFO / pad / host side driving it.
interface fifo_tx_ctrl_if;
  logic       tx_en;
  logic       have_next;
  logic [7:0] data;
  logic       next;
  logic       tx;
  logic       busy;
  logic       frame_done;

  modport master (
    input  tx_en, have_next, data,
    output next, tx, busy, frame_done
  );

  modport slave (
    output tx_en, have_next, data,
    input  next, tx, busy, frame_done
  );
endinterface

// File: rtl/fifo_tx_ctrl.sv
// Drains the COBS byte FIFO onto a UART TX line (8N1); one pop per frame, back-to-back when data waits.
// Define FIFO_TX_PARITY_EN to add an even parity bit after bit 7 (8E1, 11 bit times per frame).
module fifo_tx_ctrl #(
  parameter int ClkFreq  = 20_000_000,
  parameter int BaudRate = 115_200
) (
  input  logic           clk_i,
  input  logic           reset_i,
  fifo_tx_ctrl_if.master bus
);

  localparam int Div  = ClkFreq / BaudRate;
  localparam int CntW = $clog2(Div);
  localparam logic [CntW-1:0] CntLoad = CntW'(Div - 1);

  if (Div < 4) begin : g_div_check
    $error("fifo_tx_ctrl: ClkFreq/BaudRate must be at least 4");
  end

`ifdef FIFO_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            zero_q, zero_d;
  logic            tx_q, tx_d;
  logic            next_q, next_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef FIFO_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic pop;
  logic last;
  logic load;

  // have_next is only looked at in IDLE and on the final STOP cycle, so its stale
  // value right after a pop never causes a double pop.
  assign pop  = bus.tx_en & bus.have_next;
  assign last = (cnt_q == '0);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    state_d = state_q;
    cnt_d   = last ? cnt_q : cnt_q - 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    zero_d  = zero_q;
    next_d  = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
`ifdef FIFO_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: load = pop;
      S_START: begin
        if (last) begin
          state_d = S_DATA;
          cnt_d   = CntLoad;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (last) begin
          shift_d = shift_q >> 1;
          cnt_d   = CntLoad;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef FIFO_TX_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef FIFO_TX_PARITY_EN
      S_PAR: begin
        if (last) begin
          state_d = S_STOP;
          cnt_d   = CntLoad;
        end
      end
`endif
      S_STOP: begin
        if (last) begin
          // Delimiter flag is reported even when the next frame starts on this edge.
          done_d = zero_q;
          if (pop) load = 1'b1;
          else     state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d = S_START;
      cnt_d   = CntLoad;
      shift_d = bus.data;
      zero_d  = (bus.data == 8'h00);
      next_d  = 1'b1;
`ifdef FIFO_TX_PARITY_EN
      par_d   = ^bus.data;
`endif
    end
  end

  // Line level of the bit being sent now; registered, so tx trails the state by one cycle.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[0];
`ifdef FIFO_TX_PARITY_EN
      S_PAR:   tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign busy_d = (state_d != S_IDLE);

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      zero_q  <= 1'b0;
      tx_q    <= 1'b1;
      next_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FIFO_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      zero_q  <= zero_d;
      tx_q    <= tx_d;
      next_q  <= next_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FIFO_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.next       = next_q;
  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_fifo_tx_ctrl.sv
// Self-checking bench for fifo_tx_ctrl (Div=16): directed scenarios plus random traffic,
// compared every cycle against a frame-timeline reference model.
module tb_fifo_tx_ctrl;

  localparam int Div = 16;
`ifdef FIFO_TX_PARITY_EN
  localparam int FrameLen = 11 * Div;
`else
  localparam int FrameLen = 10 * Div;
`endif

  typedef struct {
    bit         valid;
    int         start;
    logic [7:0] data;
  } frame_t;

  logic clk = 1'b0;
  logic reset_i;

  fifo_tx_ctrl_if bus ();

  fifo_tx_ctrl #(
    .ClkFreq  (16_000_000),
    .BaudRate (1_000_000)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  logic [7:0] fifo[$];
  int         done_q[$];
  int         pop_cycles[$];
  frame_t     cur, prev;
  bit         rst_active;
  bit         async_rst_req;
  bit         tb_tx_en;
  int         exp_pops, obs_pops, busy_cnt, done_cnt;
  string      phase;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s %s @cycle %0d: got %0h, expected %0h", phase, tag, cyc, got, exp);
    end
  endtask

  // Line level a frame places on tx in cycle j: {covered, level}.
  function automatic logic [1:0] frame_level(input frame_t f, input int j);
    int o, idx;
    o = j - f.start - 1;
    if (!f.valid || o < 0 || o >= FrameLen) return 2'b00;
    idx = o / Div;
    if (idx == 0) return 2'b10;
    if (idx <= 8) return {1'b1, f.data[idx-1]};
`ifdef FIFO_TX_PARITY_EN
    if (idx == 9) return {1'b1, ^f.data};
`endif
    return 2'b11;
  endfunction

  function automatic int cur_end();
    return cur.valid ? cur.start + FrameLen - 1 : -1;
  endfunction

  task automatic model_clear();
    cur.valid  = 1'b0;
    prev.valid = 1'b0;
    done_q.delete();
  endtask

  task automatic schedule(input int s, input logic [7:0] d);
    prev = cur;
    cur  = '{valid: 1'b1, start: s, data: d};
    exp_pops++;
    if (d == 8'h00) done_q.push_back(s + FrameLen);
  endtask

  task automatic check_outputs();
    logic [1:0] lv;
    logic e_tx, e_busy, e_next, e_done;
    lv = frame_level(cur, cyc);
    if (!lv[1]) lv = frame_level(prev, cyc);
    e_tx   = lv[1] ? lv[0] : 1'b1;
    e_busy = cur.valid && cyc >= cur.start && cyc <= cur_end();
    e_next = cur.valid && cyc == cur.start;
    e_done = done_q.size() > 0 && done_q[0] == cyc;
    while (done_q.size() > 0 && done_q[0] <= cyc) void'(done_q.pop_front());
    check("tx", 32'(bus.tx), 32'(e_tx));
    check("next", 32'(bus.next), 32'(e_next));
    check("busy", 32'(bus.busy), 32'(e_busy));
    check("frame_done", 32'(bus.frame_done), 32'(e_done));
    if (bus.next === 1'b1) begin
      obs_pops++;
      pop_cycles.push_back(cyc);
    end
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.frame_done === 1'b1) done_cnt++;
  endtask

  // Inputs change only here, just after the falling edge; pops are predicted for the next edge.
  task automatic drive();
    reset_i = !rst_active;
    if (rst_active) model_clear();
    bus.tx_en     = tb_tx_en;
    bus.have_next = fifo.size() > 0;
    bus.data      = (fifo.size() > 0) ? fifo[0] : 8'($urandom);
    if (!rst_active && tb_tx_en && fifo.size() > 0 && cyc >= cur_end())
      schedule(cyc + 1, fifo[0]);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (async_rst_req) begin
      #2;
      check("pre-reset tx (bit3 of A5)", 32'(bus.tx), 32'd0);
      reset_i = 1'b0;
      #1;
      check("async tx", 32'(bus.tx), 32'd1);
      check("async busy", 32'(bus.busy), 32'd0);
      model_clear();
      rst_active    = 1'b1;
      async_rst_req = 1'b0;
    end
    @(negedge clk);
    check_outputs();
    if (cur.valid && cur.start == cyc) void'(fifo.pop_front());
    drive();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_phase(input string name);
    phase    = name;
    busy_cnt = 0;
    done_cnt = 0;
    pop_cycles.delete();
  endtask

  // Bounded wait for the model's next pop; an expired bound is a failed comparison.
  task automatic wait_pop(input int limit);
    int n;
    n = 0;
    while (!(cur.valid && cur.start == cyc) && n < limit) begin
      step();
      n++;
    end
    check("pop within bound", 32'(cur.valid && cur.start == cyc), 32'd1);
  endtask

  initial begin
    rst_active    = 1'b1;
    async_rst_req = 1'b0;
    tb_tx_en      = 1'b1;
    exp_pops      = 0;
    obs_pops      = 0;
    model_clear();
    start_phase("reset");
    drive();
    steps(5);
    rst_active = 1'b0;

    start_phase("idle");
    steps(100);
    check("idle pops", 32'(pop_cycles.size()), 32'd0);
    check("idle busy cycles", 32'(busy_cnt), 32'd0);

    start_phase("single 55");
    fifo.push_back(8'h55);
    steps(300);
    check("single pops", 32'(pop_cycles.size()), 32'd1);
    check("single busy cycles", 32'(busy_cnt), 32'(FrameLen));
    check("single done pulses", 32'(done_cnt), 32'd0);

    start_phase("queued 01 02 00");
    fifo.push_back(8'h01);
    fifo.push_back(8'h02);
    fifo.push_back(8'h00);
    steps(600);
    check("queued pops", 32'(pop_cycles.size()), 32'd3);
    if (pop_cycles.size() == 3) begin
      check("pop spacing 1-2", 32'(pop_cycles[1] - pop_cycles[0]), 32'(FrameLen));
      check("pop spacing 2-3", 32'(pop_cycles[2] - pop_cycles[1]), 32'(FrameLen));
    end
    check("queued busy cycles", 32'(busy_cnt), 32'(3 * FrameLen));
    check("queued done pulses", 32'(done_cnt), 32'd1);

    start_phase("parity 07");
    fifo.push_back(8'h07);
    fifo.push_back(8'h80);
    steps(2 * FrameLen + 40);
    check("parity pops", 32'(pop_cycles.size()), 32'd2);
    if (pop_cycles.size() == 2)
      check("parity frame spacing", 32'(pop_cycles[1] - pop_cycles[0]), 32'(FrameLen));

    start_phase("tx_en drop");
    fifo.push_back(8'h3C);
    fifo.push_back(8'hC3);
    wait_pop(50);
    steps(39);
    tb_tx_en = 1'b0;
    steps(400);
    check("drop pops", 32'(pop_cycles.size()), 32'd1);
    check("drop tx idle", 32'(bus.tx), 32'd1);
    tb_tx_en = 1'b1;
    steps(200);
    check("re-enable pops", 32'(pop_cycles.size()), 32'd2);

    start_phase("async reset");
    fifo.push_back(8'hA5);
    fifo.push_back(8'h3C);
    wait_pop(50);
    steps(72);
    async_rst_req = 1'b1;
    step();
    steps(3);
    rst_active = 1'b0;
    steps(FrameLen + 20);
    check("reset pops (lost + fresh)", 32'(pop_cycles.size()), 32'd2);

    start_phase("random");
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0 && fifo.size() < 6)
        fifo.push_back(($urandom_range(3) == 0) ? 8'h00 : 8'($urandom));
      if ($urandom_range(149) == 0) tb_tx_en = !tb_tx_en;
      step();
    end
    tb_tx_en = 1'b1;
    for (int i = 0; i < 2000 && (fifo.size() > 0 || cyc <= cur_end()); i++) step();
    steps(5);
    check("total pops", 32'(obs_pops), 32'(exp_pops));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
